// File: rtl/jt49_pkg.sv
// jt49_pkg: shared bus-mode and sequencer-state encodings for the AY bus front end.
package jt49_pkg;
    localparam int ENTRY_W = 12;
    typedef enum logic [1:0] {
        MODE_INACT = 2'b00,
        MODE_RD    = 2'b01,
        MODE_WR    = 2'b10,
        MODE_LATCH = 2'b11
    } mode_t;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RD_REQ = 2'd2,
        ST_RD_CAP = 2'd3
    } state_t;
endpackage

// File: rtl/jt49_bus_fifo.sv
// jt49_bus_fifo: write queue of {addr, data} entries; a pop in the same clk lets a push into a full queue.
module jt49_bus_fifo
    import jt49_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    logic [ENTRY_W-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    logic push_ok, pop_ok;

    assign full    = cnt == (AW+1)'(1 << AW);
    assign empty   = cnt == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/jt49_bus.sv
// jt49_bus: AY-style BDIR/BC1 bus front end that queues register writes and
// sequences reads to the PSG core only after earlier writes have drained.
module jt49_bus
    import jt49_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       bdir,
    input  logic       bc1,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       rd_valid,
    output logic       ovf,
    output logic [3:0] psg_addr,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    input  logic [7:0] psg_dout
);
    mode_t mode, prev_mode;
    state_t state, state_nx;
    logic [3:0] addr_l, rd_addr;
    logic [ENTRY_W-1:0] head;
    logic rd_pend, rd_cmd, wr_cmd, lt_cmd, take_rd, pop, full, empty;

    assign mode   = mode_t'({bdir, bc1});
    assign rd_cmd = mode != prev_mode && mode == MODE_RD;
    assign wr_cmd = mode != prev_mode && mode == MODE_WR;
    assign lt_cmd = mode != prev_mode && mode == MODE_LATCH;

    jt49_bus_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_cmd),
        .pop   (pop),
        .din   ({addr_l, cpu_din}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_nx;

    // A read arriving this very clk counts as pending so an idle bus meets the 2-clk read latency
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        take_rd  = 1'b0;
        case (state)
            ST_IDLE:
                if ((rd_pend || rd_cmd) && empty) begin
                    state_nx = ST_RD_REQ;
                    take_rd  = 1'b1;
                end else if (!empty && cen) begin
                    state_nx = ST_WRITE;
                    pop      = 1'b1;
                end
            ST_RD_REQ: state_nx = ST_RD_CAP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prev_mode <= MODE_INACT;
            addr_l    <= '0;
            rd_addr   <= '0;
            rd_pend   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            prev_mode <= mode;
            if (lt_cmd && cpu_din[7:4] == 4'd0) addr_l <= cpu_din[3:0];
            if (rd_cmd && !rd_pend) rd_addr <= addr_l;
            rd_pend <= take_rd ? 1'b0 : rd_pend || rd_cmd;
            if (wr_cmd && full && !pop) ovf <= 1'b1;
        end

    // Strobes are registered on entry so they span exactly the WRITE/RD_REQ clk
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            psg_addr <= '0;
            psg_din  <= '0;
            psg_cs_n <= 1'b1;
            psg_wr_n <= 1'b1;
            cpu_dout <= '0;
            rd_valid <= 1'b0;
        end else begin
            psg_cs_n <= !(pop || take_rd);
            psg_wr_n <= !pop;
            rd_valid <= state == ST_RD_CAP;
            if (state == ST_RD_CAP) cpu_dout <= psg_dout;
            if (pop) {psg_addr, psg_din} <= head;
            if (take_rd) psg_addr <= rd_pend ? rd_addr : addr_l;
        end
endmodule

// File: tb/tb_jt49_bus.sv
// tb_jt49_bus: directed and randomized checks of jt49_bus against a transaction-level model
// (expected core writes/reads as queues, a register-file image and an overflow flag).
module tb_jt49_bus;
    logic clk = 0, rst = 1, cen = 0, bdir = 0, bc1 = 0;
    logic [7:0] cpu_din = 0, cpu_dout, psg_din, psg_dout = 0;
    logic [3:0] psg_addr;
    logic rd_valid, ovf, psg_cs_n, psg_wr_n;

    jt49_bus #(.FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .cen(cen), .bdir(bdir), .bc1(bc1),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .rd_valid(rd_valid), .ovf(ovf),
        .psg_addr(psg_addr), .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n),
        .psg_din(psg_din), .psg_dout(psg_dout)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, cen_mode = 1, misaligned = 0, cmd_cyc = 0;
    logic cen_edge = 0;
    logic [7:0] core [16] = '{default: 8'h00};
    logic [11:0] got_wr[$], exp_wr[$];
    logic [7:0] got_rd[$], exp_rd[$];
    int wr_cyc[$], rd_cyc[$];
    logic [3:0] addr_m = 0;
    logic [7:0] regs_m [16] = '{default: 8'h00};
    logic ovf_m = 0, held = 0;
    int held_n = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        cen_edge <= cen;
    end

    initial forever begin
        @(posedge clk);
        #1 cen = cen_mode == 1 || (cen_mode == 4 && cyc % 4 == 0);
    end

    // Core stand-in: registered read data one clk after a read select
    always @(posedge clk)
        if (!psg_cs_n) begin
            if (!psg_wr_n) core[psg_addr] <= psg_din;
            else psg_dout <= core[psg_addr];
        end

    always @(negedge clk) begin
        if (!psg_cs_n && !psg_wr_n) begin
            got_wr.push_back({psg_addr, psg_din});
            wr_cyc.push_back(cyc);
            if (!cen_edge) misaligned++;
        end
        if (rd_valid) begin
            got_rd.push_back(cpu_dout);
            rd_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic bus(input logic [1:0] m, input logic [7:0] d);
        @(posedge clk);
        #1 {bdir, bc1} = m;
        cpu_din = d;
        @(posedge clk);
        #1 cmd_cyc = cyc;
        {bdir, bc1} = 2'b00;
    endtask

    task automatic op_latch(input logic [7:0] d);
        bus(2'b11, d);
        if (d[7:4] == 4'd0) addr_m = d[3:0];
    endtask

    task automatic op_write(input logic [7:0] d);
        bus(2'b10, d);
        if (held && held_n >= 4) ovf_m = 1;
        else begin
            exp_wr.push_back({addr_m, d});
            regs_m[addr_m] = d;
            if (held) held_n++;
        end
    endtask

    task automatic op_read();
        bus(2'b01, 8'h00);
        exp_rd.push_back(regs_m[addr_m]);
    endtask

    task automatic set_cen(input int m);
        cen_mode = m;
        held = m == 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic sync(input string tag);
        int n = 0;
        while ((got_wr.size() < exp_wr.size() || got_rd.size() < exp_rd.size()) && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        chk({tag, " write count"}, got_wr.size(), exp_wr.size());
        chk({tag, " read count"}, got_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_wr.size(); i++)
            if (i < got_wr.size()) chk({tag, " write entry"}, got_wr[i], exp_wr[i]);
        for (int i = 0; i < exp_rd.size(); i++)
            if (i < got_rd.size()) chk({tag, " read data"}, got_rd[i], exp_rd[i]);
        chk({tag, " ovf"}, ovf, ovf_m);
    endtask

    task automatic flush();
        got_wr.delete(); exp_wr.delete(); got_rd.delete(); exp_rd.delete();
        wr_cyc.delete(); rd_cyc.delete();
        held_n = 0;
    endtask

    task automatic wait_rd(input int n);
        for (int k = 0; k < 200 && got_rd.size() < n; k++) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset cs_n", psg_cs_n, 1);
        chk("reset wr_n", psg_wr_n, 1);
        chk("reset addr", psg_addr, 0);
        chk("reset din", psg_din, 0);
        chk("reset cpu_dout", cpu_dout, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset ovf", ovf, 0);
        rst = 0;
        set_cen(1);

        op_latch(8'h1D);
        op_write(8'h55);
        sync("bad latch");
        flush();

        set_cen(4);
        op_latch(8'h07);
        op_write(8'h38);
        sync("cen paced");
        chk("cen paced alignment", misaligned, 0);
        flush();

        set_cen(1);
        op_latch(8'h08);
        op_write(8'h1F);
        sync("prep read");
        flush();
        op_read();
        wait_rd(1);
        chk("read latency", rd_cyc.size() > 0 ? rd_cyc[0] - cmd_cyc : -1, 2);
        sync("idle read");
        flush();

        set_cen(0);
        op_latch(8'h00);
        op_write(8'hA1);
        op_write(8'hB2);
        op_read();
        repeat (10) @(posedge clk);
        chk("raw held read", got_rd.size(), 0);
        set_cen(1);
        wait_rd(1);
        chk("raw read after writes", (rd_cyc.size() > 0 && wr_cyc.size() > 1) ? rd_cyc[0] > wr_cyc[1] : 0, 1);
        sync("raw");
        flush();

        set_cen(0);
        for (int i = 0; i < 5; i++) op_write(8'h10 + 8'(i));
        repeat (4) @(posedge clk);
        chk("overflow flag", ovf, 1);
        chk("overflow held strobes", got_wr.size(), 0);
        set_cen(1);
        sync("overflow drain");
        flush();

        set_cen(0);
        bus(2'b11, 8'h0E);
        for (int i = 0; i < 4; i++) bus(2'b10, 8'hC0 + 8'(i));
        cen_mode = 1;
        for (int k = 0; k < 50 && got_wr.size() == 0; k++) @(negedge clk);
        rst = 1;
        #1 chk("reset abort cs_n", psg_cs_n, 1);
        chk("reset abort wr_n", psg_wr_n, 1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        addr_m = 0;
        ovf_m = 0;
        held = 0;
        repeat (20) @(posedge clk);
        chk("reset discard strobes", got_wr.size(), 1);
        chk("reset aborted entry", got_wr.size() > 0 ? got_wr[0] : 12'h0, 12'hEC0);
        chk("reset clears ovf", ovf, 0);
        flush();

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(1) == 1) begin
                set_cen(0);
                for (int k = 0, n = $urandom_range(1, 6); k < n; k++) begin
                    if ($urandom_range(2) == 0)
                        op_latch($urandom_range(1) ? {4'h0, 4'($urandom)} : 8'($urandom));
                    op_write(8'($urandom));
                end
                if ($urandom_range(1) == 1) op_read();
                chk("random held ovf", ovf, ovf_m);
                set_cen(1);
                sync("random held");
            end else begin
                set_cen(1);
                for (int k = 0; k < 8; k++)
                    case ($urandom_range(2))
                        0: op_latch($urandom_range(1) ? {4'h0, 4'($urandom)} : 8'($urandom));
                        1: op_write(8'($urandom));
                        default: begin
                            op_read();
                            sync("random live read");
                        end
                    endcase
                sync("random live");
            end
            flush();
        end
        chk("strobes aligned to cen", misaligned, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jt49_bus.md
JT49_BUS -- requirements
Module: jt49_bus

Interface
REQ-001 SHALL have parameter FIFO_AW, default 2, meaning the write FIFO holds 2^FIFO_AW entries.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port cen, input, 1, clock enable that paces writes to the PSG core (same enable as the core's clk_en).
REQ-005 SHALL have port bdir, input, 1, AY bus-direction pin (synchronous to clk).
REQ-006 SHALL have port bc1, input, 1, AY bus-control pin (synchronous to clk).
REQ-007 SHALL have port cpu_din, input, 8, CPU data bus in.
REQ-008 SHALL have port cpu_dout, output, 8, register read result to the CPU.
REQ-009 SHALL have port rd_valid, output, 1, one-clk pulse when cpu_dout is updated.
REQ-010 SHALL have port ovf, output, 1, sticky flag set when a write is dropped on a full FIFO.
REQ-011 SHALL have port psg_addr, output, 4, register address to the core.
REQ-012 SHALL have port psg_cs_n, output, 1, active-low chip select to the core.
REQ-013 SHALL have port psg_wr_n, output, 1, active-low write strobe to the core.
REQ-014 SHALL have port psg_din, output, 8, write data to the core.
REQ-015 SHALL have port psg_dout, input, 8, registered read data from the core (valid one clk after cs_n low).

Function
REQ-016 SHALL decode the mode {bdir,bc1}: 00 inactive, 01 read, 10 write, 11 latch address; commands act only on the clk where the mode changes into 01/10/11 from a different value.
REQ-017 SHALL, on latch, load addr_l <= cpu_din[3:0] only if cpu_din[7:4]==0; otherwise it SHALL leave addr_l unchanged.
REQ-018 SHALL, on write, push {addr_l, cpu_din} into the FIFO; on a full FIFO the entry SHALL be dropped and ovf set.
REQ-019 SHALL run an FSM with states IDLE, WRITE, RD_REQ, RD_CAP.
REQ-020 IDLE: if a read is pending and the FIFO is empty -> RD_REQ; else if the FIFO is non-empty and cen=1 -> WRITE (pop the head entry); else stay.
REQ-021 WRITE (one clk): psg_cs_n=0, psg_wr_n=0, psg_addr/psg_din = popped entry; then -> IDLE.
REQ-022 RD_REQ (one clk): psg_cs_n=0, psg_wr_n=1, psg_addr=addr_l sampled at read command; then -> RD_CAP.
REQ-023 RD_CAP: cpu_dout <= psg_dout, rd_valid=1 for that clk, psg_cs_n=1; then -> IDLE.
REQ-024 SHALL give read-after-write ordering: a read issued while writes are queued is held pending until the FIFO drains.
REQ-025 SHALL hold at most one pending read; a second read command while one is pending SHALL be ignored.
REQ-026 In IDLE, psg_cs_n=1 and psg_wr_n=1; psg_addr/psg_din SHALL hold their last values.
REQ-027 Simultaneous push and pop on the same clk SHALL both succeed, even when full (the pop frees the slot); FIFO pointers SHALL wrap modulo 2^FIFO_AW.
REQ-028 Write-to-core latency from an empty FIFO SHALL be: push at clk N, WRITE strobe at the first clk >= N+1 with cen=1.
REQ-029 Read latency SHALL be: command at clk N with an empty FIFO and IDLE -> rd_valid at N+2.

Reset
REQ-030 On rst: FSM=IDLE, FIFO empty, read pending cleared, addr_l=0, psg_addr=0, psg_din=0, psg_cs_n=1, psg_wr_n=1, cpu_dout=0, rd_valid=0, ovf=0, previous mode=00.
REQ-031 Reset mid-transaction SHALL abort immediately with no further strobe; queued writes SHALL be discarded.
REQ-032 ovf SHALL clear only on rst.

Structure
REQ-033 Mode encodings (MODE_INACT, MODE_RD, MODE_WR, MODE_LATCH) and FSM state encodings SHALL live in shared package jt49_pkg.
REQ-034 The FIFO SHALL be a separate sub-module jt49_bus_fifo (parameter AW, width 12, push/pop/full/empty).

Verification
REQ-035 Latch 0x07, write 0x38 with cen every 4 clks -> exactly one clk of psg_cs_n=0/psg_wr_n=0 with addr=7, din=0x38, aligned to a cen clk.
REQ-036 Latch 0x1D (upper nibble non-zero), then write 0x55 -> core write goes to the previous addr_l (0 after reset).
REQ-037 cen held 0, five writes with FIFO_AW=2 -> first four retained, ovf=1; enabling cen -> four strobes in push order.
REQ-038 Queue 2 writes to reg 0, then read reg 0 -> rd_valid only after both WRITE strobes, cpu_dout = second value.
REQ-039 Idle bus, latch 8, core returns 0x1F, read -> rd_valid exactly 2 clks after the read command, cpu_dout=0x1F.
REQ-040 Assert rst during WRITE with 3 entries queued -> psg_cs_n=1 in the same clk; no strobes after release until a new write.
